// File: rtl/rst_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and state-to-reset decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   rst_state_t    sequencer states HOLD, WAIT, STAGE, RUN, LOST
//   core_rst_for   reset_core level implied by a state
//   video_rst_for  reset_video level implied by a state
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    WAIT  = 3'd1,
    STAGE = 3'd2,
    RUN   = 3'd3,
    LOST  = 3'd4
  } rst_state_t;

  // Core logic is released first, in STAGE, and stays released in RUN.
  function automatic logic core_rst_for(input rst_state_t st);
    return !((st == STAGE) || (st == RUN));
  endfunction

  // Video logic is only released in RUN. This is a subset of the states where
  // core is released, so video can never be out of reset while core is held.
  function automatic logic video_rst_for(input rst_state_t st);
    return (st != RUN);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer for slow level signals entering the clock domain.
// Latency: 2 clock edges from d to q.
// Backpressure: none; q simply follows d two cycles late.
//
// Ports:
//   clock  in   1      destination clock
//   reset  in   1      synchronous active-high; clears both flop stages
//   d      in   WIDTH  asynchronous input, each bit treated independently
//   q      out  WIDTH  synchronized output
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset generator for logic on the PLL output clock; releases core then video
// after lock has been stable, re-asserts both on lock loss, counts lock losses.
// Latency: outputs are registered one edge after the state change; locked adds 2 sync edges.
// Backpressure: none; free-running sequencer.
//
// Ports:
//   clock          in   1      PLL output clock, sole clock
//   reset          in   1      synchronous active-high board reset
//   locked         in   1      PLL lock flag, asynchronous to clock
//   reset_core     out  1      active-high reset for CPU/memory logic
//   reset_video    out  1      active-high reset for VGA timing/pixel logic
//   ready          out  1      both resets released (RUN)
//   lock_loss_cnt  out  CNT_W  saturating count of STAGE/RUN -> LOST transitions
module pll_reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  output logic             reset_core,
  output logic             reset_video,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int GAP_W  = $clog2(STAGE_GAP) + 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic lock_s;

  rst_state_t        state_q, state_d;
  logic [STAB_W-1:0] stable_q, stable_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic              reset_core_q, reset_core_d;
  logic              reset_video_q, reset_video_d;
  logic              ready_q, ready_d;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (locked),
    .q    (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    // Both counters only hold a value inside their own state, so anything that
    // leaves WAIT or STAGE starts the next qualification from zero.
    stable_d = '0;
    gap_d    = '0;
    loss_d   = loss_q;

    unique case (state_q)
      HOLD: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (lock_s) begin
          if (stable_q == STAB_LAST) begin
            state_d = STAGE;
          end else begin
            stable_d = stable_q + STAB_ONE;
          end
        end
      end

      STAGE: begin
        // Lock loss wins over gap completion on the same cycle.
        if (!lock_s) begin
          state_d = LOST;
        end else if (gap_q == GAP_LAST) begin
          state_d = RUN;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d = LOST;
        end
      end

      LOST: begin
        state_d = WAIT;
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    // Count on the edge that enters LOST; only STAGE and RUN can get there.
    if ((state_d == LOST) && (state_q != LOST) && (loss_q != '1)) begin
      loss_d = loss_q + CNT_ONE;
    end

    // Outputs decode the current state and are registered, so they follow the
    // state register by exactly one edge and all three move together.
    reset_core_d  = core_rst_for(state_q);
    reset_video_d = video_rst_for(state_q);
    ready_d       = !core_rst_for(state_q) && !video_rst_for(state_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HOLD;
      stable_q      <= '0;
      gap_q         <= '0;
      loss_q        <= '0;
      reset_core_q  <= 1'b1;
      reset_video_q <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      stable_q      <= stable_d;
      gap_q         <= gap_d;
      loss_q        <= loss_d;
      reset_core_q  <= reset_core_d;
      reset_video_q <= reset_video_d;
      ready_q       <= ready_d;
    end
  end

  assign reset_core    = reset_core_q;
  assign reset_video   = reset_video_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;

endmodule
